vram_arbiter: RTL and testbench

Shares VRAM write port A (v_ada/v_din/v_cea) among up to four write requesters, such as the CPU and a hardware fill or scroll engine. It uses round-robin arbitration with optional locked bursts bounded by a cycle budget. It sits between the requesters and the ram block, in the MEMORY_CLK domain. Read port B (LCD scan-out) is untouched.

---
 rtl/vram_arb_pkg.sv | 7 +
 rtl/vram_arbiter_rr_picker.sv | 23 ++
 rtl/vram_arbiter.sv | 108 ++++++++++
 tb/tb_vram_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared state encoding, VRAM geometry and default widths for the VRAM write arbiter.
package vram_arb_pkg;
  typedef enum logic {IDLE, OWN} state_t;
  localparam int VRAM_DEPTH = 1020;  // 60x17 cells
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;
endpackage

// File: rtl/vram_arbiter_rr_picker.sv
// rr_picker: combinational N-way round-robin pick, searching upward from ptr with wrap.
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0] elig,
  input  logic [1:0]   ptr,
  output logic [N-1:0] win,
  output logic [1:0]   idx
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [1:0] off;
  logic [2:0] sum;
  always_comb begin
    dbl = {elig, elig} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? 2'(k) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= 3'(N)) ? 2'(sum - 3'(N)) : sum[1:0];
    win = (|elig) ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: round-robin VRAM write-port arbiter with budgeted locked bursts.
// Optional blanking gating of requesters is enabled by defining VSYNC_GATE_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_BURST = 16,
  parameter logic [3:0] GATE_MASK = 4'b0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]  gnt,
  output logic [AW-1:0]    v_ada,
  output logic [DW-1:0]    v_din,
  output logic             v_cea,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             drop
`ifdef VSYNC_GATE_EN
  ,
  input  logic             vsync
`endif
);
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, owner_n, idx;
  logic [7:0] cnt, cnt_n;
  logic [NREQ-1:0] gate_ok, elig, win, own_oh;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic vs_s, acc, in_range;
`ifdef VSYNC_GATE_EN
  logic [1:0] vs_q;
  always_ff @(posedge clk) vs_q <= rst ? 2'b00 : {vs_q[0], vsync};
  assign vs_s = vs_q[1];
`else
  assign vs_s = 1'b1;
`endif
  assign gate_ok = ~GATE_MASK[NREQ-1:0] | {NREQ{vs_s}};
  assign elig = req & gate_ok;
  assign own_oh = NREQ'(1) << owner;
  assign busy = (state == OWN);
  rr_picker #(.N(NREQ)) u_pick (.elig(elig), .ptr(ptr), .win(win), .idx(idx));
  always_comb begin
    gnt = '0;
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    cnt_n = cnt;
    if (state == IDLE) begin
      gnt = win;
      if (|win) begin
        ptr_n = (32'(idx) == NREQ - 1) ? 2'd0 : idx + 2'd1;
        owner_n = idx;
        if ((|(win & lock)) && MAX_BURST > 1) begin
          state_n = OWN;
          cnt_n = 8'd1;
        end
      end
    end else begin
      gnt = own_oh & req & gate_ok;
      cnt_n = cnt + 8'd1;
      // the budget check uses the incremented count so the grant this cycle is the last one
      if (!(|(own_oh & lock)) || cnt_n == 8'(MAX_BURST) || !(|(own_oh & gate_ok)))
        state_n = IDLE;
    end
    if (rst) gnt = '0;
  end
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        sel_addr = addr[i*AW +: AW];
        sel_data = data[i*DW +: DW];
      end
  end
  assign acc = |gnt;
  assign in_range = 32'(sel_addr) < 32'(VRAM_DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      v_cea <= 1'b0;
      v_ada <= '0;
      v_din <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      cnt <= cnt_n;
      v_cea <= acc && in_range;
      drop <= acc && !in_range;
      if (acc && in_range) begin
        v_ada <= sel_addr;
        v_din <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scenario tasks check grants inline; a scoreboard queue checks the registered VRAM outputs.
module tb_vram_arbiter;
  localparam int MB = 8;
  typedef struct packed {
    logic cea;
    logic drp;
    logic [9:0] ada;
    logic [7:0] din;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] lock = '0;
  logic [19:0] addr = '0;
  logic [15:0] data = '0;
  logic [1:0] gnt, owner;
  logic [9:0] v_ada;
  logic [7:0] v_din;
  logic v_cea, busy, drop;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  logic [9:0] m_ada = '0;
  logic [7:0] m_din = '0;
`ifdef VSYNC_GATE_EN
  logic vsync = 1'b1;
`endif
  vram_arbiter #(.NREQ(2), .AW(10), .DW(8), .MAX_BURST(MB), .GATE_MASK(4'b0010)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .data(data),
    .gnt(gnt), .v_ada(v_ada), .v_din(v_din), .v_cea(v_cea), .owner(owner),
    .busy(busy), .drop(drop)
`ifdef VSYNC_GATE_EN
    , .vsync(vsync)
`endif
  );
  always #5 clk = ~clk;
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({v_cea, drop, v_ada, v_din} !== e) begin
          failures++;
          $display("FAIL vram_out got cea=%b drop=%b ada=%0d din=%h want cea=%b drop=%b ada=%0d din=%h",
                   v_cea, drop, v_ada, v_din, e.cea, e.drp, e.ada, e.din);
        end
      end
    end
  end
  task automatic push_exp(input logic [1:0] g);
    exp_t e;
    logic [9:0] a;
    logic [7:0] d;
    a = g[1] ? addr[19:10] : addr[9:0];
    d = g[1] ? data[15:8] : data[7:0];
    e = '0;
    if (g != 2'b00) begin
      if (a < 10'd1020) begin
        e.cea = 1'b1;
        m_ada = a;
        m_din = d;
      end else e.drp = 1'b1;
    end
    e.ada = m_ada;
    e.din = m_din;
    q.push_back(e);
  endtask
  task automatic push_rst();
    m_ada = '0;
    m_din = '0;
    q.push_back('0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    lock = '0;
    push_rst();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    req = 2'b11;
    #1;
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got %b want 00", gnt); end
    push_rst();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({busy, owner, gnt} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state got busy=%b owner=%0d gnt=%b want 0/0/00", busy, owner, gnt);
    end
    @(negedge clk);
  endtask
  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    lock = 2'b00;
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      addr = {10'(200 + i), 10'(100 + i)};
      data = {8'(16 + i), 8'(i)};
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (gnt !== exp) begin failures++; $display("FAIL rr_gnt cycle %0d got %b want %b", i, gnt, exp); end
      push_exp(exp);
      @(negedge clk);
    end
    req = '0;
    @(negedge clk);
  endtask
  task automatic test_burst_limit();
    logic [1:0] exp;
    logic eb;
    do_reset();
    req = 2'b11;
    lock = 2'b01;
    for (int c = 1; c <= MB + 1; c++) begin
      addr = {10'(300 + c), 10'(400 + c)};
      data = {8'(c), 8'(8'h80 + c)};
      exp = (c <= MB) ? 2'b01 : 2'b10;
      eb = (c >= 2 && c <= MB);
      #1;
      checks++;
      if ({gnt, busy} !== {exp, eb}) begin
        failures++;
        $display("FAIL burst cycle %0d got gnt=%b busy=%b want gnt=%b busy=%b", c, gnt, busy, exp, eb);
      end
      push_exp(exp);
      @(negedge clk);
    end
    req = '0;
    lock = '0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_burst();
    do_reset();
    req = 2'b10;
    lock = 2'b10;
    for (int c = 1; c <= 5; c++) begin
      addr = {10'(500 + c), 10'd0};
      data = {8'(8'h40 + c), 8'h00};
      #1;
      checks++;
      if (gnt !== 2'b10) begin failures++; $display("FAIL midrst_own cycle %0d got %b want 10", c, gnt); end
      push_exp(2'b10);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL midrst_gnt got %b want 00", gnt); end
    push_rst();
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    lock = 2'b00;
    addr = {10'd7, 10'd9};
    data = {8'h77, 8'h99};
    #1;
    checks++;
    if ({busy, gnt} !== 3'b001) begin
      failures++;
      $display("FAIL midrst_after got busy=%b gnt=%b want busy=0 gnt=01", busy, gnt);
    end
    push_exp(2'b01);
    @(negedge clk);
    req = '0;
    @(negedge clk);
  endtask
  task automatic test_out_of_range();
    logic [9:0] al[3] = '{10'd1020, 10'd1019, 10'd1023};
    logic [7:0] dl[3] = '{8'hAA, 8'h55, 8'h3C};
    do_reset();
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      addr = {10'd0, al[i]};
      data = {8'h00, dl[i]};
      #1;
      checks++;
      if (gnt !== 2'b01) begin failures++; $display("FAIL oor_gnt step %0d got %b want 01", i, gnt); end
      push_exp(2'b01);
      @(negedge clk);
    end
    req = '0;
    #1;
    checks++;
    if (gnt !== 2'b00) begin failures++; $display("FAIL oor_idle got %b want 00", gnt); end
    push_exp(2'b00);
    @(negedge clk);
  endtask
  task automatic test_lock_no_req();
    logic [1:0] exp;
    logic eb;
    do_reset();
    addr = {10'd33, 10'd44};
    data = {8'h33, 8'h44};
    for (int c = 1; c <= 6; c++) begin
      req = (c == 1) ? 2'b01 : 2'b10;
      lock = (c <= 4) ? 2'b01 : 2'b00;
      exp = (c == 1) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
      eb = (c >= 2 && c <= 5);
      #1;
      checks++;
      if ({gnt, busy} !== {exp, eb}) begin
        failures++;
        $display("FAIL lock_noreq cycle %0d got gnt=%b busy=%b want gnt=%b busy=%b", c, gnt, busy, exp, eb);
      end
      push_exp(exp);
      @(negedge clk);
    end
    req = '0;
    @(negedge clk);
  endtask
`ifdef VSYNC_GATE_EN
  task automatic test_gating();
    logic [1:0] exp;
    vsync = 1'b0;
    do_reset();
    addr = {10'd60, 10'd61};
    data = {8'h60, 8'h61};
    for (int c = 1; c <= 7; c++) begin
      if (c == 1) vsync = 1'b1;
      if (c == 4) vsync = 1'b0;
      req = (c <= 3) ? 2'b10 : 2'b11;
      lock = 2'b10;
      exp = (c <= 2) ? 2'b00 : (c <= 5) ? 2'b10 : (c == 6) ? 2'b00 : 2'b01;
      #1;
      checks++;
      if (gnt !== exp) begin failures++; $display("FAIL gate cycle %0d got %b want %b", c, gnt, exp); end
      push_exp(exp);
      @(negedge clk);
    end
    req = '0;
    lock = '0;
    vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask
`endif
  initial begin
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_reset_mid_burst();
    test_out_of_range();
    test_lock_no_req();
`ifdef VSYNC_GATE_EN
    test_gating();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got %0d left want 0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
